// File: rtl/ntt_addr_gen.sv
// rtl/ntt_addr_gen.sv - NTT/INTT butterfly address, twiddle-index and control sequencer
// Walks layer/butterfly counters and registers one address pair plus twiddle index per accepted cycle.
module ntt_addr_gen #(
    parameter int N         = 256,
    parameter int ADDR_W    = 8,
    parameter int LAYER_GAP = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              inverse_i,
    input  logic              sel_red_i,
    input  logic              stall_i,
    output logic [ADDR_W-1:0] addr_a_o,
    output logic [ADDR_W-1:0] addr_b_o,
    output logic [7:0]        twiddle_idx_o,
    output logic              sel_butterfly_o,
    output logic              sel_red_o,
    output logic              valid_o,
    output logic [2:0]        layer_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [6:0] LAST_BF = 7'(N / 2 - 1);
    localparam int GW = (LAYER_GAP > 1) ? $clog2(LAYER_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((LAYER_GAP > 0) ? LAYER_GAP - 1 : 0);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, DONE} state_t;

    state_t          state;
    logic [2:0]      layer;
    logic [6:0]      bf;
    logic            inv;
    logic            red;
    logic [GW-1:0]   gap_cnt;

    logic            pair_end;
    logic            last_layer;
    logic [2:0]      first_l;
    logic [2:0]      next_l;
    logic [2:0]      pick_l;
    logic [6:0]      pick_bf;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] grp;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] nxt_a;
    logic [ADDR_W-1:0] nxt_b;
    logic [7:0]      nxt_tw;

    // The pair to load next: either the following butterfly of this layer or bf 0 of (possibly next) layer.
    always_comb begin
        pair_end   = (bf == LAST_BF);
        first_l    = inverse_i ? (sel_red_i ? 3'd6 : 3'd7) : 3'd0;
        last_layer = inv ? (layer == 3'd0) : (layer == (red ? 3'd6 : 3'd7));
        next_l     = inv ? layer - 3'd1 : layer + 3'd1;
        pick_l     = (state == RUN && pair_end) ? next_l : layer;
        pick_bf    = (state == RUN && !pair_end) ? bf + 7'd1 : 7'd0;
        len        = ADDR_W'(N / 2) >> pick_l;
        grp        = ADDR_W'(pick_bf) >> (3'd7 - pick_l);
        off        = ADDR_W'(pick_bf) & (len - ADDR_W'(1));
        nxt_a      = (grp << (4'd8 - {1'b0, pick_l})) + off;
        nxt_b      = nxt_a + len;
        nxt_tw     = inv ? 8'((9'd2 << pick_l) - 9'd1 - {1'b0, grp})
                         : ((8'd1 << pick_l) + grp);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            layer         <= 3'd0;
            bf            <= 7'd0;
            inv           <= 1'b0;
            red           <= 1'b0;
            gap_cnt       <= '0;
            addr_a_o      <= '0;
            addr_b_o      <= '0;
            twiddle_idx_o <= 8'd0;
            valid_o       <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (start_i) begin
                    inv    <= inverse_i;
                    red    <= sel_red_i;
                    layer  <= first_l;
                    bf     <= 7'd0;
                    busy_o <= 1'b1;
                    state  <= LOAD;
                end
                LOAD: begin
                    addr_a_o      <= nxt_a;
                    addr_b_o      <= nxt_b;
                    twiddle_idx_o <= nxt_tw;
                    valid_o       <= 1'b1;
                    state         <= RUN;
                end
                RUN: if (!stall_i) begin
                    if (!pair_end) begin
                        bf            <= bf + 7'd1;
                        addr_a_o      <= nxt_a;
                        addr_b_o      <= nxt_b;
                        twiddle_idx_o <= nxt_tw;
                    end else if (last_layer) begin
                        valid_o <= 1'b0;
                        done_o  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        layer <= next_l;
                        bf    <= 7'd0;
                        if (LAYER_GAP == 0) begin
                            addr_a_o      <= nxt_a;
                            addr_b_o      <= nxt_b;
                            twiddle_idx_o <= nxt_tw;
                        end else begin
                            valid_o <= 1'b0;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        addr_a_o      <= nxt_a;
                        addr_b_o      <= nxt_b;
                        twiddle_idx_o <= nxt_tw;
                        valid_o       <= 1'b1;
                        state         <= RUN;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sel_butterfly_o = inv;
    assign sel_red_o       = red;
    assign layer_o         = layer;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// tb/tb_ntt_addr_gen.sv - scoreboard bench for ntt_addr_gen with directed pair expectations
module tb_ntt_addr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, start0, inverse, sel_red, stall;
    logic stall0 = 1'b0;

    logic [7:0] addr_a, addr_b, tw;
    logic       sel_bf, sel_rd, valid, busy, done;
    logic [2:0] layer;
    logic [7:0] addr_a0, addr_b0, tw0;
    logic       sel_bf0, sel_rd0, valid0, busy0, done0;
    logic [2:0] layer0;

    ntt_addr_gen #(.N(256), .ADDR_W(8), .LAYER_GAP(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .inverse_i(inverse),
        .sel_red_i(sel_red), .stall_i(stall), .addr_a_o(addr_a), .addr_b_o(addr_b),
        .twiddle_idx_o(tw), .sel_butterfly_o(sel_bf), .sel_red_o(sel_rd),
        .valid_o(valid), .layer_o(layer), .busy_o(busy), .done_o(done)
    );

    ntt_addr_gen #(.N(256), .ADDR_W(8), .LAYER_GAP(0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start0), .inverse_i(inverse),
        .sel_red_i(sel_red), .stall_i(stall0), .addr_a_o(addr_a0), .addr_b_o(addr_b0),
        .twiddle_idx_o(tw0), .sel_butterfly_o(sel_bf0), .sel_red_o(sel_rd0),
        .valid_o(valid0), .layer_o(layer0), .busy_o(busy0), .done_o(done0)
    );

    typedef struct {
        int         n;
        logic [7:0] a, b, t;
        logic [2:0] l;
        logic       sb, sr;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb0_q[$];
    exp_t e_m, e_m0;
    int   checks = 0, errors = 0;
    int   cnt = 0, cnt0 = 0, total = 0, total0 = 0;
    int   cyc = 0, t_start = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int n, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] t, input logic [2:0] l,
                                input logic sb, input logic sr);
        exp_t e;
        e.n = n; e.a = a; e.b = b; e.t = t; e.l = l; e.sb = sb; e.sr = sr;
        return e;
    endfunction

    // Monitors: count accepted pairs per run and compare against queued expectations by pair index.
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt = 0;
        end else begin
            if (valid && !stall) begin
                if (sb_q.size() > 0 && sb_q[0].n == cnt) begin
                    e_m = sb_q.pop_front();
                    chk($sformatf("pair%0d", e_m.n), {3'b0, layer, sel_bf, sel_rd, addr_a, addr_b, tw},
                        {3'b0, e_m.l, e_m.sb, e_m.sr, e_m.a, e_m.b, e_m.t});
                end
                cnt++;
            end
            if (done) begin
                total = cnt;
                cnt = 0;
                chk("sb_drained", sb_q.size(), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt0 = 0;
        end else begin
            if (valid0) begin
                if (sb0_q.size() > 0 && sb0_q[0].n == cnt0) begin
                    e_m0 = sb0_q.pop_front();
                    chk($sformatf("gap0_pair%0d", e_m0.n), {3'b0, layer0, sel_bf0, sel_rd0, addr_a0, addr_b0, tw0},
                        {3'b0, e_m0.l, e_m0.sb, e_m0.sr, e_m0.a, e_m0.b, e_m0.t});
                end
                cnt0++;
            end
            if (done0) begin
                total0 = cnt0;
                cnt0 = 0;
                chk("gap0_sb_drained", sb0_q.size(), 0);
            end
        end
    end

    task automatic go(input logic iv, input logic rd, input bit on0);
        @(posedge clk); #1;
        inverse = iv; sel_red = rd;
        if (on0) start0 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        t_start = cyc;
        start = 1'b0; start0 = 1'b0;
        inverse = ~iv; sel_red = ~rd;
    endtask

    task automatic wait_done(input bit on0, input int exp_cyc, input int exp_total, input string nm);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (on0 ? done0 : done) break;
        end
        #1;
        chk({nm, "_done_cycle"}, cyc - t_start, exp_cyc);
        chk({nm, "_valid_total"}, on0 ? total0 : total, exp_total);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start0 = 1'b0;
        inverse = 1'b0; sel_red = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {addr_a, addr_b, tw, sel_bf, sel_rd, valid, layer, busy, done}, 32'd0);
        rst_n = 1'b1;

        // Kyber forward, with a start pulse and input toggles mid-run
        sb_q.push_back(mk(0,   8'd0,   8'd128, 8'd1,   3'd0, 1'b0, 1'b1));
        sb_q.push_back(mk(127, 8'd127, 8'd255, 8'd1,   3'd0, 1'b0, 1'b1));
        sb_q.push_back(mk(192, 8'd128, 8'd192, 8'd3,   3'd1, 1'b0, 1'b1));
        sb_q.push_back(mk(895, 8'd253, 8'd255, 8'd127, 3'd6, 1'b0, 1'b1));
        go(1'b0, 1'b1, 1'b0);
        chk("busy_before_valid", {busy, valid}, 2'b10);
        @(posedge clk); #1;
        chk("first_valid_latency", valid, 1'b1);
        repeat (300) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(1'b0, 909, 896, "kyber_fwd");

        // start held through DONE is ignored there and accepted from IDLE; begins Kyber inverse
        sb_q.push_back(mk(0,   8'd0,   8'd2,   8'd127, 3'd6, 1'b1, 1'b1));
        sb_q.push_back(mk(1,   8'd1,   8'd3,   8'd127, 3'd6, 1'b1, 1'b1));
        sb_q.push_back(mk(2,   8'd4,   8'd6,   8'd126, 3'd6, 1'b1, 1'b1));
        sb_q.push_back(mk(895, 8'd127, 8'd255, 8'd1,   3'd0, 1'b1, 1'b1));
        start = 1'b1; inverse = 1'b1; sel_red = 1'b1;
        @(posedge clk); #1;
        chk("start_in_done_ignored", busy, 1'b0);
        @(posedge clk); #1;
        t_start = cyc;
        start = 1'b0; inverse = 1'b0; sel_red = 1'b0;
        chk("start_after_done_accepted", busy, 1'b1);
        wait_done(1'b0, 909, 896, "kyber_inv");

        // Dilithium forward
        sb_q.push_back(mk(0,    8'd0,   8'd128, 8'd1,   3'd0, 1'b0, 1'b0));
        sb_q.push_back(mk(896,  8'd0,   8'd1,   8'd128, 3'd7, 1'b0, 1'b0));
        sb_q.push_back(mk(1023, 8'd254, 8'd255, 8'd255, 3'd7, 1'b0, 1'b0));
        go(1'b0, 1'b0, 1'b0);
        wait_done(1'b0, 1039, 1024, "dil_fwd");

        // Dilithium inverse
        sb_q.push_back(mk(0,    8'd0,   8'd1,   8'd255, 3'd7, 1'b1, 1'b0));
        sb_q.push_back(mk(1023, 8'd127, 8'd255, 8'd1,   3'd0, 1'b1, 1'b0));
        go(1'b1, 1'b0, 1'b0);
        wait_done(1'b0, 1039, 1024, "dil_inv");

        // Three stalled edges on Kyber forward bf 5
        sb_q.push_back(mk(5,   8'd5,   8'd133, 8'd1,   3'd0, 1'b0, 1'b1));
        sb_q.push_back(mk(6,   8'd6,   8'd134, 8'd1,   3'd0, 1'b0, 1'b1));
        sb_q.push_back(mk(895, 8'd253, 8'd255, 8'd127, 3'd6, 1'b0, 1'b1));
        go(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (valid && addr_a == 8'd4) break;
        end
        @(posedge clk); #1 stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", {8'd0, addr_a, addr_b, tw}, {8'd0, 8'd5, 8'd133, 8'd1});
            @(posedge clk);
        end
        #1 stall = 1'b0;
        @(negedge clk);
        chk("stall_hold_last", {8'd0, addr_a, addr_b, tw}, {8'd0, 8'd5, 8'd133, 8'd1});
        @(negedge clk);
        chk("stall_release", {8'd0, addr_a, addr_b, tw}, {8'd0, 8'd6, 8'd134, 8'd1});
        wait_done(1'b0, 912, 896, "kyber_stall");

        // Reset mid-run at layer 3 bf 40, then a clean restart
        sb_q.push_back(mk(424, 8'd72, 8'd88, 8'd10, 3'd3, 1'b0, 1'b1));
        go(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (valid && layer == 3'd3 && addr_a == 8'd72) break;
        end
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_mid_run", {addr_a, addr_b, tw, sel_bf, sel_rd, valid, layer, busy, done}, 32'd0);
        #1 rst_n = 1'b1;
        sb_q.push_back(mk(0,   8'd0,   8'd128, 8'd1,   3'd0, 1'b0, 1'b1));
        sb_q.push_back(mk(895, 8'd253, 8'd255, 8'd127, 3'd6, 1'b0, 1'b1));
        go(1'b0, 1'b1, 1'b0);
        wait_done(1'b0, 909, 896, "restart");

        // No inter-layer gap
        sb0_q.push_back(mk(127, 8'd127, 8'd255, 8'd1, 3'd0, 1'b0, 1'b1));
        sb0_q.push_back(mk(128, 8'd0,   8'd64,  8'd2, 3'd1, 1'b0, 1'b1));
        go(1'b0, 1'b1, 1'b1);
        wait_done(1'b1, 897, 896, "gap0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_addr_gen.md
Name: ntt_addr_gen

Overview:
- Sequencer directly upstream of the butterfly unit for in-place NTT/INTT over 256 coefficients.
- Walks layers, groups and offsets in the required order.
- Emits one coefficient-memory address pair plus a twiddle-ROM index per cycle, together with the sel_butterfly/sel_red controls the butterfly consumes.
- Supports Kyber (7 layers) and Dilithium (8 layers), forward (Cooley-Tukey) and inverse (Gentleman-Sande).

Parameters:
- N, 256, coefficients per polynomial; fixed, must be 256.
- ADDR_W, 8, coefficient address width (log2 N).
- LAYER_GAP, 2, idle cycles inserted between layers for write-back drain; 0 allowed.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset: synchronous, active-low.
- start_i  in  1  start request; sampled only in IDLE.
- inverse_i  in  1  0 = forward NTT (CT), 1 = inverse NTT (GS); latched at start.
- sel_red_i  in  1  1 = Kyber, 0 = Dilithium; latched at start.
- stall_i  in  1  backpressure; 1 holds the current pair and all counters.
- addr_a_o  out  ADDR_W  address of butterfly input a.
- addr_b_o  out  ADDR_W  address of butterfly input b (addr_a_o + len).
- twiddle_idx_o  out  8  twiddle ROM index.
- sel_butterfly_o  out  1  latched inverse_i, to butterfly.
- sel_red_o  out  1  latched sel_red_i, to butterfly.
- valid_o  out  1  pair on outputs is valid.
- layer_o  out  3  current layer depth l (len = 128 >> l).
- busy_o  out  1  high from the cycle after start acceptance through the DONE cycle.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n_i = 0 at an edge, any state including mid-run): state goes to IDLE; every output is 0; counters are cleared; the run is abandoned.
- All outputs are registered.
- States:
  - IDLE -> RUN on start_i. Latch inverse_i and sel_red_i. Set l0 as follows: forward l0 = 0; inverse l0 = 6 for Kyber, 7 for Dilithium. Set bf = 0.
  - RUN: outputs show the pair for (l, bf). A pair is accepted on an edge where valid_o = 1 and stall_i = 0.
    - On acceptance with bf < 127: bf increments.
    - On acceptance with bf = 127 and this is not the last layer: go to GAP (or straight to the next layer if LAYER_GAP = 0).
    - On acceptance with bf = 127 and this is the last layer: go to DONE.
  - GAP: valid_o = 0 for exactly LAYER_GAP cycles; stall_i is ignored. Then return to RUN with bf = 0 and l advanced (forward l+1, inverse l-1).
  - DONE: done_o = 1 and valid_o = 0 for one cycle; then IDLE. busy_o drops in IDLE.
- Layer order:
  - Kyber forward l = 0..6; Kyber inverse l = 6..0.
  - Dilithium forward l = 0..7; Dilithium inverse l = 7..0.
- Address and index arithmetic (per layer):
  - len = 128 >> l
  - group = bf >> (7 - l)
  - offset = bf & (len - 1)
  - addr_a = group * 2 * len + offset
  - addr_b = addr_a + len
  - Forward twiddle_idx = (1 << l) + group.
  - Inverse twiddle_idx = (2 << l) - 1 - group.
  - The ROM handles negation/inverse constants. Index range is 1..127 for Kyber and 1..255 for Dilithium; index 0 is never emitted.
- Latency: start_i sampled at edge k -> first valid pair visible after edge k+1.
- Throughput: one pair per unstalled cycle. Each layer is 128 pairs, so Kyber = 896 pairs and Dilithium = 1024 pairs.
- Stall:
  - stall_i high while valid_o = 1 freezes all outputs and counters.
  - stall_i is ignored in IDLE, GAP and DONE.
  - stall_i high on the last pair delays DONE until the pair is accepted.
- start_i while busy is ignored. inverse_i and sel_red_i changes mid-run have no effect.
- start_i asserted during the DONE cycle is ignored; it is accepted from IDLE on the next cycle.

Test Plan:
- Kyber forward, no stall, LAYER_GAP = 2, start at edge 0:
  - First pair (0, 128, idx 1); pair 127 is (127, 255, idx 1).
  - Layer 1, bf 64 -> (128, 192, idx 3).
  - Last pair (253, 255, idx 127).
  - done_o pulses exactly 896 + 12 + 1 cycles after the first valid; total valid count is 896.
- Dilithium forward:
  - Layer 7 first pair (0, 1, idx 128); last pair (254, 255, idx 255).
  - 1024 valid pairs; sel_red_o = 0 throughout.
- Kyber inverse:
  - First pair (0, 2, idx 127); layer 6 bf 1 -> (1, 3, idx 127); bf 2 -> (4, 6, idx 126).
  - Final layer pair (127, 255, idx 1); sel_butterfly_o = 1.
  - Dilithium inverse first pair (0, 1, idx 255).
- stall_i held for 3 cycles on Kyber forward bf 5:
  - Outputs remain (5, 133, 1) for 4 cycles, then (6, 134, 1); no pair is skipped or duplicated.
- Reset and start interactions:
  - rst_n_i low at Kyber forward layer 3, bf 40 -> next cycle all outputs 0 and state IDLE.
  - A new start restarts from (0, 128, 1).
  - start_i pulsed mid-run -> ignored; pair sequence is unchanged.
- LAYER_GAP = 0, Kyber forward:
  - Layer 0 bf 127 is followed immediately by layer 1 bf 0 (0, 64, idx 2) with no valid_o gap.
